sw_input_port: RTL



---
 rtl/cpu_pkg.sv | 13 +
 rtl/sw_input_port_if.sv | 26 ++
 rtl/debounce_sync.sv | 69 ++++++
 rtl/sw_input_port.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings and constants for the model computer's panel peripherals.
package cpu_pkg;

    localparam int unsigned DEBOUNCE_20MS = 32'd2000000;

    typedef enum logic [1:0] {
        B_IDLE         = 2'd0,
        B_PRESS_WAIT   = 2'd1,
        B_PRESSED      = 2'd2,
        B_RELEASE_WAIT = 2'd3
    } btn_state_e;

endpackage

// File: rtl/sw_input_port_if.sv
// Operator-panel input bus: raw switch/button inputs, CPU read handshake, captured byte.
interface sw_input_port_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic [WIDTH-1:0] SW_RAW;
    logic             BTN_RAW;
    logic             RD_ACK;
    logic [WIDTH-1:0] DATA_OUT;
    logic             DATA_VALID;
    logic             OVERRUN;
    logic [WIDTH-1:0] SW_STABLE;

    // Panel/CPU side
    modport master (
        output SW_RAW, BTN_RAW, RD_ACK,
        input  DATA_OUT, DATA_VALID, OVERRUN, SW_STABLE
    );

    // Input port side
    modport slave (
        input  SW_RAW, BTN_RAW, RD_ACK,
        output DATA_OUT, DATA_VALID, OVERRUN, SW_STABLE
    );

endinterface

// File: rtl/debounce_sync.sv
// Two-flop synchroniser with an optional shared-counter debounce filter.
// DEBOUNCE_CYCLES = 0 gives a plain synchroniser (out_o is the synced value).
module debounce_sync #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] out_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Metastability guard for the asynchronous panel inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= raw_i;
            sync_q <= meta_q;
        end
    end

    if (DEBOUNCE_CYCLES != 0) begin : g_filter
        localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
        localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

        logic [WIDTH-1:0] prev_q;
        logic [WIDTH-1:0] stable_q, stable_d;
        logic [CW-1:0]    cnt_q, cnt_d;

        // Counter tracks how long the synced vector has held one value that differs from stable
        always_comb begin
            stable_d = stable_q;
            cnt_d    = cnt_q;
            if (sync_q == stable_q) begin
                cnt_d = '0;
            end else if (sync_q != prev_q) begin
                cnt_d = CW'(1);
            end else if (cnt_q == CNT_LAST) begin
                stable_d = sync_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // Debounce state registers
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                prev_q   <= '0;
                stable_q <= '0;
                cnt_q    <= '0;
            end else begin
                prev_q   <= sync_q;
                stable_q <= stable_d;
                cnt_q    <= cnt_d;
            end
        end

        assign out_o = stable_q;
    end else begin : g_pass
        assign out_o = sync_q;
    end

endmodule

// File: rtl/sw_input_port.sv
// Operator-panel capture port: debounced switches latched on each ENTER press,
// handed to the CPU with a valid/ack handshake and a sticky overrun flag.
module sw_input_port
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS,
    parameter int unsigned CNT_W           = 21
) (
    input  logic                clk,
    input  logic                CLEARn,
    sw_input_port_if.slave      bus
);

    localparam logic [CNT_W-1:0] BCNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sw_stable;
    logic             btn_sync;

    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic             press_q, press_d;

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;

    debounce_sync #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_db (
        .clk   (clk),
        .rst_n (CLEARn),
        .raw_i (bus.SW_RAW),
        .out_o (sw_stable)
    );

    debounce_sync #(
        .WIDTH           (1),
        .DEBOUNCE_CYCLES (0)
    ) u_btn_sync (
        .clk   (clk),
        .rst_n (CLEARn),
        .raw_i (bus.BTN_RAW),
        .out_o (btn_sync)
    );

    // Button debounce FSM; press_d fires once when a press is confirmed
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        press_d = 1'b0;
        case (state_q)
            B_IDLE: begin
                if (btn_sync) begin
                    state_d = B_PRESS_WAIT;
                    bcnt_d  = CNT_W'(1);
                end
            end
            B_PRESS_WAIT: begin
                if (!btn_sync) begin
                    state_d = B_IDLE;
                    bcnt_d  = '0;
                end else if (bcnt_q == BCNT_LAST) begin
                    state_d = B_PRESSED;
                    bcnt_d  = '0;
                    press_d = 1'b1;
                end else begin
                    bcnt_d = bcnt_q + CNT_W'(1);
                end
            end
            B_PRESSED: begin
                if (!btn_sync) begin
                    state_d = B_RELEASE_WAIT;
                    bcnt_d  = CNT_W'(1);
                end
            end
            B_RELEASE_WAIT: begin
                if (btn_sync) begin
                    state_d = B_PRESSED;
                    bcnt_d  = '0;
                end else if (bcnt_q == BCNT_LAST) begin
                    state_d = B_IDLE;
                    bcnt_d  = '0;
                end else begin
                    bcnt_d = bcnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = B_IDLE;
                bcnt_d  = '0;
            end
        endcase
    end

    // Holding register: first unconsumed byte wins unless the CPU acks in the same cycle
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (press_q) begin
            if (!valid_q) begin
                data_d  = sw_stable;
                valid_d = 1'b1;
                if (bus.RD_ACK) begin
                    ovr_d = 1'b0;
                end
            end else if (bus.RD_ACK) begin
                data_d = sw_stable;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (bus.RD_ACK) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge CLEARn) begin
        if (!CLEARn) begin
            state_q <= B_IDLE;
            bcnt_q  <= '0;
            press_q <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            press_q <= press_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.DATA_OUT   = data_q;
    assign bus.DATA_VALID = valid_q;
    assign bus.OVERRUN    = ovr_q;
    assign bus.SW_STABLE  = sw_stable;

endmodule
